// File: rtl/prf_wb_arbiter_pkg.sv
// Shared widths and the buffered writeback entry for the PRF writeback arbiter.
package prf_pkg;

  localparam int XLEN = 64;
  localparam int PHYS = 64;
  localparam int PW   = $clog2(PHYS);
  localparam int RW   = 5;

  typedef struct packed {
    logic [PW-1:0]   pdst;
    logic [XLEN-1:0] data;
    logic [RW-1:0]   rob_idx;
  } wb_entry_t;

endpackage

// File: rtl/prf_wb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: one-entry buffer per FU, round-robin pick, registered
// drive of the PRF write port, CDB wakeup and ROB completion.
module prf_wb_arbiter
  import prf_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_FU-1:0]      fu_valid,
  output logic [NUM_FU-1:0]      fu_ready,
  input  logic [NUM_FU*PW-1:0]   fu_pdst,
  input  logic [NUM_FU*XLEN-1:0] fu_data,
  input  logic [NUM_FU*RW-1:0]   fu_rob_idx,
  output logic                   prf_we,
  output logic [PW-1:0]          prf_waddr,
  output logic [XLEN-1:0]        prf_wdata,
  output logic                   cdb_valid,
  output logic [PW-1:0]          cdb_tag,
  output logic                   rob_cmpl_valid,
  output logic [RW-1:0]          rob_cmpl_idx
);

  localparam int IW = $clog2(NUM_FU);

  wb_entry_t         entry_q [NUM_FU];
  wb_entry_t         win_entry;
  logic [NUM_FU-1:0] v_q, v_d, req, grant, accept;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d, winner;
  logic              any_grant;

  logic              we_q, cmpl_q;
  logic [PW-1:0]     waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [RW-1:0]     rob_idx_q;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  // A flush freezes the arbiter: nothing is granted and nothing accepted.
  assign req       = flush ? '0 : v_q;
  assign fu_ready  = flush ? '0 : (~v_q | grant);
  assign accept    = fu_valid & fu_ready;
  assign any_grant = |grant;
  assign win_entry = entry_q[winner];

  always_comb begin
    v_d      = flush ? '0 : ((v_q & ~grant) | accept);
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (winner == IW'(NUM_FU - 1)) ? '0 : winner + IW'(1);
    end
  end

  // NOTE: the payload has no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        entry_q[i] <= '{pdst:    fu_pdst[i*PW +: PW],
                        data:    fu_data[i*XLEN +: XLEN],
                        rob_idx: fu_rob_idx[i*RW +: RW]};
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      rr_ptr_q  <= '0;
      we_q      <= 1'b0;
      cmpl_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rob_idx_q <= '0;
    end else begin
      v_q      <= v_d;
      rr_ptr_q <= rr_ptr_d;
      cmpl_q   <= any_grant;
      // p0 is the hardwired zero register: complete it, never write or wake.
      we_q     <= any_grant && (win_entry.pdst != '0);
      if (any_grant) begin
        waddr_q   <= win_entry.pdst;
        wdata_q   <= win_entry.data;
        rob_idx_q <= win_entry.rob_idx;
      end
    end
  end

  assign prf_we         = we_q;
  assign prf_waddr      = waddr_q;
  assign prf_wdata      = wdata_q;
  assign cdb_valid      = we_q;
  assign cdb_tag        = waddr_q;
  assign rob_cmpl_valid = cmpl_q;
  assign rob_cmpl_idx   = rob_idx_q;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: a table of single-result vectors plus
// hand-written contention, fairness, reset, flush and streaming sequences.
module tb_prf_wb_arbiter;
  import prf_pkg::*;

  localparam int NFU = 4;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic [NFU-1:0]       fu_valid, fu_ready;
  logic [NFU*PW-1:0]    fu_pdst;
  logic [NFU*XLEN-1:0]  fu_data;
  logic [NFU*RW-1:0]    fu_rob_idx;
  logic                 prf_we, cdb_valid, rob_cmpl_valid;
  logic [PW-1:0]        prf_waddr, cdb_tag;
  logic [XLEN-1:0]      prf_wdata;
  logic [RW-1:0]        rob_cmpl_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              fu;
    logic [PW-1:0]   pdst;
    logic [XLEN-1:0] data;
    logic [RW-1:0]   rob;
    logic            exp_we;
    logic            exp_cmpl;
  } vec_t;

  vec_t vecs [4];

  prf_wb_arbiter #(.NUM_FU(NFU)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .fu_pdst        (fu_pdst),
    .fu_data        (fu_data),
    .fu_rob_idx     (fu_rob_idx),
    .prf_we         (prf_we),
    .prf_waddr      (prf_waddr),
    .prf_wdata      (prf_wdata),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .rob_cmpl_valid (rob_cmpl_valid),
    .rob_cmpl_idx   (rob_cmpl_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic [PW-1:0] p,
                        input logic [XLEN-1:0] d, input logic [RW-1:0] r);
    fu_pdst[i*PW +: PW]       = p;
    fu_data[i*XLEN +: XLEN]   = d;
    fu_rob_idx[i*RW +: RW]    = r;
  endtask

  task automatic check_idle(input string name);
    check({name, " prf_we"}, prf_we, 0);
    check({name, " cdb_valid"}, cdb_valid, 0);
    check({name, " cmpl_valid"}, rob_cmpl_valid, 0);
  endtask

  task automatic check_wb(input string name, input logic we, input logic [PW-1:0] a,
                          input logic [XLEN-1:0] d, input logic [RW-1:0] r);
    check({name, " prf_we"}, prf_we, we);
    check({name, " cdb_valid"}, cdb_valid, we);
    check({name, " waddr"}, prf_waddr, a);
    check({name, " cdb_tag"}, cdb_tag, a);
    check({name, " wdata"}, prf_wdata, d);
    check({name, " cmpl_valid"}, rob_cmpl_valid, 1);
    check({name, " cmpl_idx"}, rob_cmpl_idx, r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{fu: 1, pdst: 6'd5,  data: 64'hDEAD,                rob: 5'd3,  exp_we: 1'b1, exp_cmpl: 1'b1};
    vecs[1] = '{fu: 3, pdst: 6'd0,  data: 64'h1234,                rob: 5'd7,  exp_we: 1'b0, exp_cmpl: 1'b1};
    vecs[2] = '{fu: 0, pdst: 6'd63, data: 64'hFFFF_FFFF_FFFF_FFFF, rob: 5'd31, exp_we: 1'b1, exp_cmpl: 1'b1};
    vecs[3] = '{fu: 2, pdst: 6'd1,  data: 64'h0123_4567_89AB_CDEF, rob: 5'd0,  exp_we: 1'b1, exp_cmpl: 1'b1};

    rst = 1'b1; flush = 1'b0; fu_valid = '0;
    fu_pdst = '0; fu_data = '0; fu_rob_idx = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset waddr", prf_waddr, 0);
    check("reset wdata", prf_wdata, 0);
    check("reset cmpl_idx", rob_cmpl_idx, 0);
    rst = 1'b0;
    #1 check("reset ready", fu_ready, 4'hF);

    // Table: one result at a time, visible two cycles later for one cycle.
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      fu_valid = '0;
      fu_valid[vecs[n].fu] = 1'b1;
      set_fu(vecs[n].fu, vecs[n].pdst, vecs[n].data, vecs[n].rob);
      #1 check($sformatf("vec%0d ready", n), fu_ready[vecs[n].fu], 1);
      @(negedge clk);
      fu_valid = '0;
      @(negedge clk);
      check($sformatf("vec%0d prf_we", n), prf_we, vecs[n].exp_we);
      check($sformatf("vec%0d cdb_valid", n), cdb_valid, vecs[n].exp_we);
      check($sformatf("vec%0d waddr", n), prf_waddr, vecs[n].pdst);
      check($sformatf("vec%0d cdb_tag", n), cdb_tag, vecs[n].pdst);
      check($sformatf("vec%0d wdata", n), prf_wdata, vecs[n].data);
      check($sformatf("vec%0d cmpl_valid", n), rob_cmpl_valid, vecs[n].exp_cmpl);
      check($sformatf("vec%0d cmpl_idx", n), rob_cmpl_idx, vecs[n].rob);
      @(negedge clk);
      check_idle($sformatf("vec%0d after", n));
    end

    // Reset mid-operation: two buffered results must be lost.
    fu_valid = 4'b0011;
    set_fu(0, 6'd8, 64'h88, 5'd8);
    set_fu(1, 6'd9, 64'h99, 5'd9);
    @(negedge clk);
    fu_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle($sformatf("midreset c%0d", k));
      #1 check($sformatf("midreset ready c%0d", k), fu_ready, 4'hF);
      @(negedge clk);
    end

    // Contention: four results drain 10..13 in pointer order.
    fu_valid = 4'hF;
    for (int i = 0; i < NFU; i++) set_fu(i, PW'(10 + i), XLEN'(100 + i), RW'(i));
    #1 check("cont ready c0", fu_ready, 4'hF);
    @(negedge clk);
    fu_valid = '0;
    for (int k = 0; k < NFU; k++) begin
      #1 check($sformatf("cont ready c%0d", k + 1), fu_ready, XLEN'((1 << (k + 1)) - 1));
      @(negedge clk);
      check_wb($sformatf("cont wb%0d", k), 1'b1, PW'(10 + k), XLEN'(100 + k), RW'(k));
    end
    @(negedge clk);
    check_idle("cont after");

    // Fairness: FU0 streams, FU2 once; grants go 0, 2, 0.
    fu_valid = 4'b0101;
    set_fu(0, 6'd1, 64'hA0, 5'd1);
    set_fu(2, 6'd30, 64'hA2, 5'd2);
    @(negedge clk);
    fu_valid = 4'b0001;
    @(negedge clk);
    check_wb("fair g0", 1'b1, 6'd1, 64'hA0, 5'd1);
    #1 check("fair ready wait", fu_ready, 4'b1110);
    @(negedge clk);
    check_wb("fair g2", 1'b1, 6'd30, 64'hA2, 5'd2);
    @(negedge clk);
    check_wb("fair g0b", 1'b1, 6'd1, 64'hA0, 5'd1);
    fu_valid = '0;
    repeat (4) @(negedge clk);
    check_idle("fair drained");

    // Flush with three buffers full.
    fu_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_fu(i, PW'(50 + i), XLEN'(50 + i), RW'(20 + i));
    @(negedge clk);
    fu_valid = '0;
    flush = 1'b1;
    #1 check("flush ready", fu_ready, 4'h0);
    @(negedge clk);
    flush = 1'b0;
    check_idle("flush c1");
    #1 check("flush ready after", fu_ready, 4'hF);
    @(negedge clk);
    check_idle("flush c2");
    fu_valid = 4'b1000;
    set_fu(3, 6'd40, 64'hBEEF, 5'd9);
    @(negedge clk);
    fu_valid = '0;
    @(negedge clk);
    check_wb("flush new", 1'b1, 6'd40, 64'hBEEF, 5'd9);

    // Back-to-back on FU2: eight writes 20..27 with no bubbles.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) begin
        fu_valid = 4'b0100;
        set_fu(2, PW'(20 + k), XLEN'(64'hC00 + k), RW'(k));
        #1 check($sformatf("b2b ready%0d", k), fu_ready[2], 1);
      end else begin
        fu_valid = '0;
      end
      if (k >= 2 && k < 10)
        check_wb($sformatf("b2b wb%0d", k - 2), 1'b1, PW'(18 + k), XLEN'(64'hC00 + k - 2), RW'(k - 2));
      else if (k == 10)
        check_idle("b2b after");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
